// File: rtl/sequence_frame_pkg.sv
// sequence_frame_pkg: shared FSM state enum and sync-preamble constants for sequence_frame_tx; macro SEQUENCE_FRAME_TX_PARITY_EN adds the PARITY state
package sequence_frame_pkg;
  localparam int SYNC_LEN = 4;
  localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1101;
`ifdef SEQUENCE_FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif
endpackage

// File: rtl/sequence_frame_shreg.sv
// sequence_frame_shreg: loadable MSB-first shift register; ports clk, rst, load_i, en_i, d_i[W], sout_o (current MSB)
module sequence_frame_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic         sout_o
);
  logic [W-1:0] sr_q;
  always_ff @(posedge clk)
    if (rst) sr_q <= '0;
    else if (load_i) sr_q <= d_i;
    else if (en_i) sr_q <= sr_q << 1;
  assign sout_o = sr_q[W-1];
endmodule

// File: rtl/sequence_frame_tx.sv
// sequence_frame_tx: serialises a 4-bit sync preamble then DATA_W payload bits MSB first (plus even parity with SEQUENCE_FRAME_TX_PARITY_EN); ports clk, rst, start, din[DATA_W], ready, o, o_valid, done
module sequence_frame_tx
  import sequence_frame_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SYNC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              o,
  output logic              o_valid,
  output logic              done
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sidx_q, sidx_d;
  logic            o_q, o_d, v_q, v_d, done_q, done_d;
  logic            load, shift, sout;
`ifdef SEQUENCE_FRAME_TX_PARITY_EN
  logic            par_q, par_d;
`endif
  sequence_frame_shreg #(.W(DATA_W)) u_shreg (
    .clk(clk), .rst(rst), .load_i(load), .en_i(shift), .d_i(din), .sout_o(sout)
  );
  // Outputs are registered: each edge decides the bit that o carries in the following cycle,
  // so state_q always names the phase of the bit currently on o.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sidx_d  = sidx_q;
    o_d     = 1'b0;
    v_d     = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SYNC;
        cnt_d   = '0;
        sidx_d  = '0;
        load    = 1'b1;
        o_d     = SYNC_PATTERN[SYNC_LEN-1];
        v_d     = 1'b1;
      end
      SYNC: begin
        v_d = 1'b1;
        if (sidx_q == 2'(SYNC_LEN - 1)) begin
          state_d = DATA;
          cnt_d   = CW'(1);
          shift   = 1'b1;
          o_d     = sout;
        end else begin
          sidx_d = sidx_q + 2'd1;
          o_d    = SYNC_PATTERN[~sidx_d];
        end
      end
      DATA: if (cnt_q == CW'(DATA_W)) begin
`ifdef SEQUENCE_FRAME_TX_PARITY_EN
        state_d = PARITY;
        o_d     = par_q;
        v_d     = 1'b1;
`else
        state_d = IDLE;
        done_d  = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
        shift = 1'b1;
        o_d   = sout;
        v_d   = 1'b1;
      end
`ifdef SEQUENCE_FRAME_TX_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
`ifdef SEQUENCE_FRAME_TX_PARITY_EN
  // Accumulates every payload bit as it is shifted out.
  assign par_d = load ? 1'b0 : shift ? par_q ^ sout : par_q;
  always_ff @(posedge clk) par_q <= rst ? 1'b0 : par_d;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sidx_q  <= '0;
      o_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sidx_q  <= sidx_d;
      o_q     <= o_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  assign ready   = state_q == IDLE;
  assign o       = o_q;
  assign o_valid = v_q;
  assign done    = done_q;
endmodule

// File: tb/tb_sequence_frame_tx.sv
// tb_sequence_frame_tx: directed self-checking bench for sequence_frame_tx
module tb_sequence_frame_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready, o, o_valid, done;
  int checks = 0;
  int errors = 0;
`ifdef SEQUENCE_FRAME_TX_PARITY_EN
  localparam int NBITS = 13;
`else
  localparam int NBITS = 12;
`endif
  sequence_frame_tx #(.DATA_W(8), .SYNC_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .ready(ready), .o(o), .o_valid(o_valid), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    chk({tag, ".o"}, 32'(o), 32'd0);
    chk({tag, ".o_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask
  // Issues start with d in cycle T and checks every frame bit; busy injects start=1/din=FF at T+3.
  // With hold, start stays high so the next call's accept lands in this frame's done cycle.
  task automatic frame(input string tag, input logic [7:0] d, input bit busy, input bit hold);
    logic [12:0] f;
    f = {4'b1101, d, ^d};
    start = 1'b1;
    din = d;
    tick;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= NBITS; k++) begin
      chk($sformatf("%s.o[%0d]", tag, k), 32'(o), 32'(f[13-k]));
      chk($sformatf("%s.v[%0d]", tag, k), 32'(o_valid), 32'd1);
      chk($sformatf("%s.rdy[%0d]", tag, k), 32'(ready), 32'd0);
      chk($sformatf("%s.done[%0d]", tag, k), 32'(done), 32'd0);
      if (busy && k == 3) begin start = 1'b1; din = 8'hFF; end
      if (busy && k == 4) start = 1'b0;
      tick;
    end
    chk_idle({tag, ".donecyc"}, 1'b1);
    if (!hold) begin
      tick;
      chk_idle({tag, ".after"}, 1'b0);
    end
  endtask
  initial begin
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle($sformatf("rst%0d", i), 1'b0);
    end
    rst = 1'b0;
    start = 1'b0;
    tick;
    chk_idle("post_rst", 1'b0);
    frame("a5", 8'hA5, 1'b0, 1'b0);
    frame("busy", 8'hA5, 1'b1, 1'b0);
    frame("c3", 8'hC3, 1'b0, 1'b0);
    start = 1'b1;
    din = 8'hA5;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle("abort", 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick;
      chk_idle($sformatf("abort_after%0d", i), 1'b0);
    end
    frame("b2b1", 8'hA5, 1'b0, 1'b1);
    frame("b2b2", 8'h3C, 1'b0, 1'b0);
`ifdef SEQUENCE_FRAME_TX_PARITY_EN
    frame("par01", 8'h01, 1'b0, 1'b0);
`else
    frame("x01", 8'h01, 1'b0, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
